// File: rtl/riscv_pkg.sv
// Shared encodings and the decoded-fields bundle for the RV32I-subset decode stage.
package riscv_pkg;

  localparam int ILEN = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic [4:0]      rd_addr;
    logic            writeback_en;
    logic            writeback_from_mem;
    logic            alu_rs2_reg;
    logic [ILEN-1:0] imm;
    logic            add_en;
    logic            sub_en;
    logic            xor_en;
    logic            or_en;
    logic            and_en;
    logic            skip_instr;
  } dec_t;

  // add x0,x0,x0 marked as skipped
  localparam dec_t BUBBLE = '{
    rd_addr:            5'd0,
    writeback_en:       1'b1,
    writeback_from_mem: 1'b0,
    alu_rs2_reg:        1'b0,
    imm:                '0,
    add_en:             1'b1,
    sub_en:             1'b0,
    xor_en:             1'b0,
    or_en:              1'b0,
    and_en:             1'b0,
    skip_instr:         1'b1
  };

endpackage

// File: rtl/regfile.sv
// Architectural register file: two async read ports with write-first bypass,
// one synchronous write port, x0 hardwired to zero.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wb_en,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [AW-1:0]   i_rs1_idx,
  input  logic [AW-1:0]   i_rs2_idx,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr;

  assign w_wr = i_wb_en && (i_wb_addr != '0);

  // NOTE: the array is cleared on reset because architectural state must read
  // zero after reset; this forces flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every reader sees
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_rs1_data = (i_rs1_idx == '0)                     ? '0        :
                      (w_wr && (i_wb_addr == i_rs1_idx))    ? i_wb_data :
                                                              r_regs[i_rs1_idx];
  assign o_rs2_data = (i_rs2_idx == '0)                     ? '0        :
                      (w_wr && (i_wb_addr == i_rs2_idx))    ? i_wb_data :
                                                              r_regs[i_rs2_idx];

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction register, decode, EX-forward flags and load-use
// stall against the previously issued instruction.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            writeback_en,
  output logic            writeback_from_mem,
  output logic            alu_rs2_reg,
  output logic [XLEN-1:0] imm,
  output logic            add_en,
  output logic            sub_en,
  output logic            xor_en,
  output logic            or_en,
  output logic            and_en,
  output logic            skip_instr,
  output logic            rs1_take_prev1,
  output logic            rs2_take_prev1,
  output logic            illegal_instr
);

  logic            r_ir_valid;
  logic [31:0]     r_ir;
  logic [4:0]      r_prev_rd;
  logic            r_prev_load;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1_idx;
  logic [4:0]      w_rs2_idx;
  logic [ILEN-1:0] w_imm_i;
  dec_t            w_dec;
  dec_t            w_out;
  logic            w_legal;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_is_lw;
  logic            w_stall;
  logic            w_issue;
  logic            w_fire;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;

  assign w_opcode  = r_ir[6:0];
  assign w_funct3  = r_ir[14:12];
  assign w_funct7  = r_ir[31:25];
  assign w_rs1_idx = r_ir[19:15];
  assign w_rs2_idx = r_ir[24:20];
  assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would infer a latch.
  always_comb begin
    w_dec              = BUBBLE;
    w_dec.rd_addr      = r_ir[11:7];
    w_dec.add_en       = 1'b0;
    w_dec.skip_instr   = 1'b0;
    w_legal            = 1'b0;
    w_uses_rs1         = 1'b0;
    w_uses_rs2         = 1'b0;
    w_is_lw            = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_dec.alu_rs2_reg = 1'b1;
        w_uses_rs1        = 1'b1;
        w_uses_rs2        = 1'b1;
        unique case (w_funct3)
          F3_ADD: begin
            w_dec.add_en = (w_funct7 == F7_BASE);
            w_dec.sub_en = (w_funct7 == F7_SUB);
            w_legal      = (w_funct7 == F7_BASE) || (w_funct7 == F7_SUB);
          end
          F3_XOR:  begin w_dec.xor_en = 1'b1; w_legal = 1'b1; end
          F3_OR:   begin w_dec.or_en  = 1'b1; w_legal = 1'b1; end
          F3_AND:  begin w_dec.and_en = 1'b1; w_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_IMM: begin
        w_dec.imm  = w_imm_i;
        w_uses_rs1 = 1'b1;
        unique case (w_funct3)
          F3_ADD:  begin w_dec.add_en = 1'b1; w_legal = 1'b1; end
          F3_XOR:  begin w_dec.xor_en = 1'b1; w_legal = 1'b1; end
          F3_OR:   begin w_dec.or_en  = 1'b1; w_legal = 1'b1; end
          F3_AND:  begin w_dec.and_en = 1'b1; w_legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          w_dec.imm                = w_imm_i;
          w_dec.add_en             = 1'b1;
          w_dec.writeback_from_mem = 1'b1;
          w_uses_rs1               = 1'b1;
          w_is_lw                  = 1'b1;
          w_legal                  = 1'b1;
        end
      end
      default: ;
    endcase
    if (!w_legal) begin
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
    end
  end

  assign w_stall = r_ir_valid && r_prev_load && (r_prev_rd != 5'd0) &&
                   ((w_uses_rs1 && (w_rs1_idx == r_prev_rd)) ||
                    (w_uses_rs2 && (w_rs2_idx == r_prev_rd)));
  assign w_issue     = r_ir_valid && !w_stall;
  assign w_fire      = w_issue && w_legal;
  assign instr_ready = !r_ir_valid || w_issue;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rs1_idx  (w_rs1_idx),
    .i_rs2_idx  (w_rs2_idx),
    .o_rs1_data (w_rf_rs1),
    .o_rs2_data (w_rf_rs2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir_valid  <= 1'b0;
      r_ir        <= '0;
      r_prev_rd   <= '0;
      r_prev_load <= 1'b0;
    end else begin
      if (instr_ready) begin
        r_ir_valid <= instr_valid;
        if (instr_valid) r_ir <= instr;
      end
      // Only a legal issue leaves a producer behind for the next instruction.
      r_prev_rd   <= w_fire ? w_dec.rd_addr : 5'd0;
      r_prev_load <= w_fire && w_is_lw;
    end
  end

  assign w_out = w_fire ? w_dec : BUBBLE;

  assign rd_addr            = w_out.rd_addr;
  assign writeback_en       = w_out.writeback_en;
  assign writeback_from_mem = w_out.writeback_from_mem;
  assign alu_rs2_reg        = w_out.alu_rs2_reg;
  assign imm                = XLEN'($signed(w_out.imm));
  assign add_en             = w_out.add_en;
  assign sub_en             = w_out.sub_en;
  assign xor_en             = w_out.xor_en;
  assign or_en              = w_out.or_en;
  assign and_en             = w_out.and_en;
  assign skip_instr         = w_out.skip_instr;
  assign rs1                = w_fire ? w_rf_rs1 : '0;
  assign rs2                = w_fire ? w_rf_rs2 : '0;
  assign illegal_instr      = w_issue && !w_legal;

  assign rs1_take_prev1 = w_issue && w_uses_rs1 && (w_rs1_idx == r_prev_rd) &&
                          (r_prev_rd != 5'd0) && !r_prev_load;
  assign rs2_take_prev1 = w_issue && w_uses_rs2 && (w_rs2_idx == r_prev_rd) &&
                          (r_prev_rd != 5'd0) && !r_prev_load;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, forwarding, load-use stall, illegal
// discard, regfile bypass and mid-operation reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr;
  logic [31:0] rs1, rs2, imm;
  logic        writeback_en, writeback_from_mem, alu_rs2_reg;
  logic        add_en, sub_en, xor_en, or_en, and_en;
  logic        skip_instr, rs1_take_prev1, rs2_take_prev1, illegal_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_valid        (instr_valid),
    .instr              (instr),
    .instr_ready        (instr_ready),
    .wb_en              (wb_en),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .rd_addr            (rd_addr),
    .rs1                (rs1),
    .rs2                (rs2),
    .writeback_en       (writeback_en),
    .writeback_from_mem (writeback_from_mem),
    .alu_rs2_reg        (alu_rs2_reg),
    .imm                (imm),
    .add_en             (add_en),
    .sub_en             (sub_en),
    .xor_en             (xor_en),
    .or_en              (or_en),
    .and_en             (and_en),
    .skip_instr         (skip_instr),
    .rs1_take_prev1     (rs1_take_prev1),
    .rs2_take_prev1     (rs2_take_prev1),
    .illegal_instr      (illegal_instr)
  );

  // Control bundle: rd, wb, wb_mem, rs2_reg, {add,sub,xor,or,and}, skip, t1, t2, illegal, ready
  logic [17:0] obs_ctl;
  assign obs_ctl = {rd_addr, writeback_en, writeback_from_mem, alu_rs2_reg,
                    add_en, sub_en, xor_en, or_en, and_en, skip_instr,
                    rs1_take_prev1, rs2_take_prev1, illegal_instr, instr_ready};

  function automatic logic [17:0] ctl(input logic [4:0] rd, input logic wb,
      input logic wbm, input logic r2, input logic [4:0] alu, input logic skip,
      input logic t1, input logic t2, input logic ill, input logic rdy);
    return {rd, wb, wbm, r2, alu, skip, t1, t2, ill, rdy};
  endfunction

  localparam logic [4:0] ALU_ADD = 5'b10000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    rst = 1'b0; instr_valid = 1'b0; instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12 rst = 1'b1;
    tick(); #2;
    exp = ctl(5'd0, 1, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL reset_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if ({rs1, rs2, imm} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", rs1, rs2, imm); end
    checks++;
  endtask

  task automatic test_addi_neg();
    logic [17:0] exp;
    present(32'hFFB0_0093); #2;
    exp = ctl(5'd1, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL addi_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if (imm !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_imm: got %h want fffffffb", imm); end
    checks++;
    if (rs1 !== 32'h0) begin errors++; $display("FAIL addi_rs1: got %h want 0", rs1); end
    checks++;
    tick(); #2;
    exp = ctl(5'd0, 1, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL addi_after_empty: got %h want %h", obs_ctl, exp); end
    checks++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp;
    present(32'h0050_0093);            // ADDI x1,x0,5
    instr = 32'h0010_8133;             // ADD x2,x1,x1
    instr_valid = 1'b1;
    #2;
    exp = ctl(5'd1, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL b2b_addi_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if (imm !== 32'd5) begin errors++; $display("FAIL b2b_addi_imm: got %h want 5", imm); end
    checks++;
    tick(); instr_valid = 1'b0; #2;
    exp = ctl(5'd2, 1, 0, 1, ALU_ADD, 0, 1, 1, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL b2b_add_fwd: got %h want %h", obs_ctl, exp); end
    checks++;
    if (imm !== 32'h0) begin errors++; $display("FAIL b2b_add_imm: got %h want 0", imm); end
    checks++;
    tick();
  endtask

  task automatic test_load_use();
    logic [17:0] exp;
    present(32'h0001_A203);            // LW x4,0(x3)
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1234;
    instr = 32'h4002_02B3;             // SUB x5,x4,x0
    instr_valid = 1'b1;
    #2;
    exp = ctl(5'd4, 1, 1, 0, ALU_ADD, 0, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL lw_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if (rs1 !== 32'h0000_1234) begin errors++; $display("FAIL lw_bypass_rs1: got %h want 00001234", rs1); end
    checks++;
    tick(); instr_valid = 1'b0; wb_en = 1'b0; #2;
    exp = ctl(5'd0, 1, 0, 0, ALU_ADD, 1, 0, 0, 0, 0);
    if (obs_ctl !== exp) begin errors++; $display("FAIL lu_bubble: got %h want %h", obs_ctl, exp); end
    checks++;
    tick();
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hCAFE_0004;
    #2;
    exp = ctl(5'd5, 1, 0, 1, ALU_SUB, 0, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL lu_sub_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if (rs1 !== 32'hCAFE_0004) begin errors++; $display("FAIL lu_sub_rs1: got %h want cafe0004", rs1); end
    checks++;
    if (rs2 !== 32'h0) begin errors++; $display("FAIL lu_sub_rs2: got %h want 0", rs2); end
    checks++;
    tick(); wb_en = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [17:0] exp;
    present(32'h0000_2023);            // SW: unsupported
    instr = 32'h0070_0313;             // ADDI x6,x0,7
    instr_valid = 1'b1;
    #2;
    exp = ctl(5'd0, 1, 0, 0, ALU_ADD, 1, 0, 0, 1, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL illegal_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    tick(); instr_valid = 1'b0; #2;
    exp = ctl(5'd6, 1, 0, 0, ALU_ADD, 0, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL after_illegal_ctl: got %h want %h", obs_ctl, exp); end
    checks++;
    if (imm !== 32'd7) begin errors++; $display("FAIL after_illegal_imm: got %h want 7", imm); end
    checks++;
    tick();
  endtask

  task automatic test_regfile();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_0007;
    tick();
    wb_en = 1'b0;
    present(32'h0033_8033);            // ADD x0,x7,x3
    #2;
    if ({rs1, rs2} !== {32'hA5A5_0007, 32'h0000_1234}) begin
      errors++; $display("FAIL rf_stored: got %h %h want a5a50007 00001234", rs1, rs2);
    end
    checks++;
    present(32'h0000_0033);            // ADD x0,x0,x0 while WB targets x0
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #2;
    if ({rs1, rs2} !== 64'h0) begin errors++; $display("FAIL rf_x0_bypass: got %h %h want 0 0", rs1, rs2); end
    checks++;
    tick(); wb_en = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    logic [17:0] exp;
    present(32'h0001_A203);            // LW x4,0(x3)
    instr = 32'h4002_02B3;             // SUB x5,x4,x0
    instr_valid = 1'b1;
    tick(); instr_valid = 1'b0; #2;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL mr_stalled: got ready=%b want 0", instr_ready); end
    checks++;
    rst = 1'b0; #1;
    exp = ctl(5'd0, 1, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
    if (obs_ctl !== exp) begin errors++; $display("FAIL mr_async_bubble: got %h want %h", obs_ctl, exp); end
    checks++;
    tick(); tick();
    @(negedge clk); rst = 1'b1;
    tick(); #2;
    if (obs_ctl !== exp) begin errors++; $display("FAIL mr_ir_dropped: got %h want %h", obs_ctl, exp); end
    checks++;
    instr_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      instr = {7'd0, r, r, 3'b000, 5'd0, 7'b0110011};
      tick(); #2;
      if ({rs1, rs2} !== 64'h0) begin
        errors++; $display("FAIL mr_reg_clear x%0d: got %h %h want 0 0", i, rs1, rs2);
      end
      checks++;
    end
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi_neg();
    test_back_to_back();
    test_load_use();
    test_illegal();
    test_regfile();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the pipelined RV32I-subset core. Pipeline: IF → id_stage → id_ex → EX → WB (memory read and regfile write in WB).
- Holds the fetched instruction in an internal instruction register (IR) and owns the architectural register file.
- Decodes the instruction and drives every *_in field of id_ex.
- Detects hazards against the previously issued instruction: flags EX forwarding (rs*_take_prev1), or stalls one cycle and inserts a bubble for load-use.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers (x0 hardwired zero).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch has an instruction
- instr  in  32  instruction word
- instr_ready  out  1  id_stage accepts instr this cycle
- wb_en  in  1  regfile write enable from WB
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data
- rd_addr  out  5  destination register
- rs1, rs2  out  XLEN  operand values
- writeback_en, writeback_from_mem  out  1  writeback controls
- alu_rs2_reg  out  1  1 = ALU operand B from rs2; 0 = from imm
- imm  out  XLEN  sign-extended I-immediate
- add_en, sub_en, xor_en, or_en, and_en  out  1  one-hot ALU select
- skip_instr  out  1  bubble marker
- rs1_take_prev1, rs2_take_prev1  out  1  forward operand from EX result
- illegal_instr  out  1  one-cycle pulse when an unsupported IR word is discarded

Behaviour:
- Reset (rst=0, async):
  - IR invalid; prev_rd=0, prev_load=0.
  - All 31 writable registers cleared to 0.
  - instr_ready=1.
  - Outputs show the bubble (see below); illegal_instr=0.
- Bubble value: rd_addr=0, writeback_en=1, add_en=1, skip_instr=1; every other output 0. It is the add x0,x0,x0 NOP, flagged as skipped.
- Output timing: outputs are combinational from IR + regfile + prev state; id_ex registers them. Decode latency is one cycle from IR capture to id_ex.
- IR capture: on a clock edge where instr_valid && instr_ready.
- Flow control: instr_ready = !ir_valid || issue.
- issue = ir_valid && !stall.
- stall = ir_valid && prev_load && prev_rd!=0 && ((uses_rs1 && rs1_idx==prev_rd) || (uses_rs2 && rs2_idx==prev_rd)).
- Decode:
  - R-type (opcode 0110011): funct3 000/funct7 0000000 = ADD, funct3 000/funct7 0100000 = SUB, funct3 100 = XOR, 110 = OR, 111 = AND. Uses rs1 and rs2; alu_rs2_reg=1.
  - OP-IMM (opcode 0010011): funct3 000/100/110/111 = ADDI/XORI/ORI/ANDI. Uses rs1 only; alu_rs2_reg=0.
  - LW (opcode 0000011, funct3 010): add_en=1, alu_rs2_reg=0, writeback_from_mem=1.
  - imm = sign-extended instr[31:20] for I-type, 0 for R-type.
  - writeback_en=1, skip_instr=0 for all legal instructions.
  - Any other encoding is illegal.
- Issue cycle (legal): outputs = decode; IR consumed. On the edge, prev_rd<=rd and prev_load<=is_LW.
- Issue cycle (illegal): outputs = bubble; illegal_instr=1; IR consumed; prev cleared to 0/0.
- Stall cycle: outputs = bubble; IR held; instr_ready=0; prev cleared to 0/0. After exactly one bubble the load is in WB and the regfile bypass supplies its data.
- Empty cycle (!ir_valid): outputs = bubble; prev cleared to 0/0.
- Forwarding: rsN_take_prev1 = issue && usesN && idxN==prev_rd && prev_rd!=0 && !prev_load. The flag is 0 for bubbles.
- Regfile read:
  - x0 always reads 0.
  - Write-first bypass: wb_en && wb_addr==idx && idx!=0 returns wb_data in the same cycle.
  - Writes to x0 are ignored.
  - Unused rs2 (I-type) reads as regfile[instr[24:20]]; it is don't-care and not checked.
- Simultaneous events:
  - A WB write and an IR read of the same register in one cycle returns the new value.
  - A stall and instr_valid in the same cycle: the incoming instruction is not accepted (instr_ready=0).
- Mid-operation reset: the pending IR is dropped; the instruction must be re-fetched.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD;
  - funct3/funct7 constants;
  - a decoded-fields struct type;
  - the BUBBLE constant of that type.
- Sub-module regfile: 2 async read ports, 1 sync write port, write-first bypass, async active-low clear. id_stage handles decode, hazards, IR and prev state.

Test Plan:
- Reset then an idle cycle → bubble outputs (rd=0, add_en=1, writeback_en=1, skip_instr=1), instr_ready=1, illegal_instr=0.
- ADDI x1,x0,-5 (0xFFB00093) → rd_addr=1, imm=0xFFFFFFFB, add_en=1, alu_rs2_reg=0, rs1=0, take_prev1 flags 0.
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back → second issue has rs1_take_prev1=1, rs2_take_prev1=1, no stall.
- WB writes x3=0x1234 in the cycle LW x4,0(x3) issues → rs1=0x1234 via bypass. Next instruction SUB x5,x4,x0 presented → one bubble with instr_ready=0, then SUB issues with rs1_take_prev1=0; prev is cleared after the bubble, so the x4 value comes from the regfile bypass.
- Instruction 0x00002023 (SW) → bubble, illegal_instr pulses 1 cycle, IR consumed, the following instruction issues normally.
- Assert rst=0 asynchronously while IR holds a stalled SUB → outputs bubble immediately, instr_ready=1 after release, x1..x31 read 0.
